// File: rtl/adc_pkt_pkg.sv
// Shared types and helpers for the ADC stream packetizer.
package adc_pkt_pkg;

  typedef enum logic [1:0] {
    SINGLE = 2'd0,
    GATED  = 2'd1,
    CONT   = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  // Test-pattern sample value before truncation to the sample width.
  function automatic logic [31:0] test_sample(input logic [31:0] word_idx,
                                              input logic [31:0] lane,
                                              input logic [31:0] num_ch);
    return word_idx * num_ch + lane;
  endfunction

endpackage

// File: rtl/adc_stream_packetizer_fifo.sv
// Synchronous first-word-fall-through FIFO; dout is valid whenever !empty.
module sync_fwft_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic           push_ok, pop_ok;

  always_comb begin
    push_ok  = push && (count_q != FULL_CNT);
    pop_ok   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  assign dout  = mem[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/adc_stream_packetizer.sv
// Multi-lane ADC sample packetizer: capture FSM, overflow tracking and AXIS output via FWFT FIFO.
module adc_stream_packetizer
  import adc_pkt_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 512,
  parameter int DSIZE_W    = 32
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic                         in_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0]   in_data,
  input  logic [1:0]                   mode,
  input  logic [DSIZE_W-1:0]           dsize,
  input  logic                         test,
  input  logic                         start,
  input  logic                         sync,
  input  logic                         abort,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [NUM_CH*SAMPLE_W-1:0]   m_axis_tdata,
  output logic [NUM_CH*SAMPLE_W/8-1:0] m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic                         idle,
  output logic                         overflow,
  output logic [DSIZE_W-1:0]           word_count
);

  localparam int DATA_W = NUM_CH * SAMPLE_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  state_t              state_q, state_d;
  mode_t               mode_q, mode_d;
  logic                test_q, test_d;
  logic [DSIZE_W-1:0]  dsize_q, dsize_d;
  logic                stop_req_q, stop_req_d;
  logic                overflow_q, overflow_d;
  logic [DSIZE_W-1:0]  word_count_q, word_count_d;

  logic                fifo_push, fifo_pop, fifo_empty;
  logic [DATA_W:0]     fifo_din, fifo_dout;
  logic [CNT_W-1:0]    fifo_count;

  logic [DATA_W-1:0]   pattern, word_data;
  logic                accept, wr_last, room;
  logic [DSIZE_W-1:0]  wc_inc;

  always_comb begin
    pattern = '0;
    for (int k = 0; k < NUM_CH; k++)
      pattern[k*SAMPLE_W +: SAMPLE_W] =
        SAMPLE_W'(test_sample(32'(word_count_q), 32'(k), 32'(NUM_CH)));
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    test_d       = test_q;
    dsize_d      = dsize_q;
    stop_req_d   = stop_req_q;
    overflow_d   = overflow_q;
    word_count_d = word_count_q;
    accept       = 1'b0;
    wr_last      = 1'b0;
    fifo_push    = 1'b0;
    fifo_pop     = !fifo_empty && m_axis_tready;
    word_data    = test_q ? pattern : in_data;
    wc_inc       = (word_count_q == '1) ? word_count_q : word_count_q + 1'b1;
    // One slot is always held back so the packet's last word can never be lost.
    room         = fifo_count < CNT_W'(FIFO_DEPTH - 1);

    case (state_q)
      IDLE: begin
        if (start) begin
          case (mode)
            2'd1:    mode_d = GATED;
            2'd2:    mode_d = CONT;
            default: mode_d = SINGLE;
          endcase
          test_d       = test;
          dsize_d      = (dsize == '0) ? DSIZE_W'(1) : dsize;
          overflow_d   = 1'b0;
          word_count_d = '0;
          stop_req_d   = 1'b0;
          state_d      = (mode == 2'd1) ? ARMED : CAPTURE;
        end
      end
      ARMED: begin
        if (abort) begin
          state_d = IDLE;
        end else if (in_valid && sync) begin
          accept  = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (in_valid) begin
          accept  = 1'b1;
          wr_last = (mode_q == GATED) ? !sync : (word_count_q == dsize_q - 1'b1);
          if (wr_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_pop && fifo_dout[DATA_W]) begin
          if (mode_q == CONT && !stop_req_q && !abort) begin
            state_d      = CAPTURE;
            word_count_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Dropped words still count so packet length tracks real time.
    if (accept) begin
      if (wr_last || room) fifo_push  = 1'b1;
      else                 overflow_d = 1'b1;
      word_count_d = wc_inc;
    end

    if (abort) stop_req_d = 1'b1;
  end

  assign fifo_din = {wr_last, word_data};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= IDLE;
      mode_q       <= SINGLE;
      test_q       <= 1'b0;
      dsize_q      <= '0;
      stop_req_q   <= 1'b0;
      overflow_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      test_q       <= test_d;
      dsize_q      <= dsize_d;
      stop_req_q   <= stop_req_d;
      overflow_q   <= overflow_d;
      word_count_q <= word_count_d;
    end
  end

  sync_fwft_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
  assign m_axis_tlast  = !fifo_empty && fifo_dout[DATA_W];
  assign m_axis_tkeep  = '1;
  assign idle          = (state_q == IDLE);
  assign overflow      = overflow_q;
  assign word_count    = word_count_q;

endmodule

// File: tb/tb_adc_stream_packetizer.sv
// Scoreboard bench for adc_stream_packetizer (NUM_CH=2, SAMPLE_W=16, FIFO_DEPTH=16).
module tb_adc_stream_packetizer;

  localparam int NUM_CH = 2;
  localparam int SAMPLE_W = 16;
  localparam int DEPTH = 16;
  localparam int DSIZE_W = 32;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] dsize = '0;
  logic        test = 1'b0;
  logic        start = 1'b0;
  logic        sync = 1'b0;
  logic        abort = 1'b0;
  logic        tvalid, tlast, tready = 1'b0;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        idle, overflow;
  logic [31:0] word_count;

  int errors = 0;
  int checks = 0;
  int last_seen = 0;
  logic [32:0] exp_q[$];

  always #5 ACLK = ~ACLK;

  adc_stream_packetizer #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .FIFO_DEPTH(DEPTH), .DSIZE_W(DSIZE_W)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .in_valid(in_valid), .in_data(in_data),
    .mode(mode), .dsize(dsize), .test(test), .start(start), .sync(sync),
    .abort(abort), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
    .idle(idle), .overflow(overflow), .word_count(word_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Test word i: lane1 = 2i+1, lane0 = 2i.
  function automatic logic [31:0] pat(input int i);
    logic [15:0] hi, lo;
    hi = 16'(2 * i + 1);
    lo = 16'(2 * i);
    return {hi, lo};
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [31:0] ds, input logic t);
    mode = m; dsize = ds; test = t; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int maxc, input bit rnd);
    int n = 0;
    while (!idle && n < maxc) begin
      if (rnd) tready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (rnd) tready = 1'b1;
    check({name, "_idle_reached"}, idle, 1'b1);
    check({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  // Monitor: compares each accepted beat and checks hold-while-stalled.
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data;
  logic        stall_last;
  always @(negedge ACLK) begin
    logic [32:0] e;
    if (!ARESETN) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("stall_hold", {tvalid, tlast, tdata}, {1'b1, stall_last, stall_data});
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got %0h last=%0b, expected none", tdata, tlast);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", tdata, e[31:0]);
          check("beat_last", tlast, e[32]);
        end
        if (tlast) last_seen++;
      end
      stall_prev = tvalid && !tready;
      stall_data = tdata;
      stall_last = tlast;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    // Reset state
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tdata", tdata, 0);
    check("rst_idle", idle, 1);
    check("rst_overflow", overflow, 0);
    check("rst_word_count", word_count, 0);
    check("tkeep", tkeep, 4'hF);
    ARESETN = 1'b1;
    tick();

    // 1: SINGLE dsize=4 test pattern
    tready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3) ? 1'b1 : 1'b0, pat(i)});
    do_start(2'd0, 32'd4, 1'b1);
    check("t1_idle_low", idle, 0);
    n = 0;
    @(negedge ACLK);
    while (!(tvalid && tready && tlast) && n < 50) begin @(negedge ACLK); n++; end
    check("t1_last_found", tvalid && tlast, 1);
    check("t1_idle_before_pop", idle, 0);
    @(negedge ACLK);
    check("t1_idle_after_pop", idle, 1);
    check("t1_word_count", word_count, 4);
    repeat (3) tick();
    check("t1_idle_ignores_in", tvalid, 0);
    check("t1_sb_empty", exp_q.size(), 0);

    // 2: GATED, three sync words plus one trailing
    in_valid = 1'b0;
    do_start(2'd1, 32'd0, 1'b0);
    in_valid = 1'b1; sync = 1'b0; in_data = 32'hDEAD_0000;
    tick();
    check("t2_armed_no_write", tvalid, 0);
    exp_q.push_back({1'b0, 32'hA0A0_0001});
    exp_q.push_back({1'b0, 32'hA0A0_0002});
    exp_q.push_back({1'b0, 32'hA0A0_0003});
    exp_q.push_back({1'b1, 32'hA0A0_0004});
    sync = 1'b1; in_data = 32'hA0A0_0001; tick();
    in_data = 32'hA0A0_0002; tick();
    in_data = 32'hA0A0_0003; tick();
    sync = 1'b0; in_data = 32'hA0A0_0004; tick();
    in_data = 32'hBEEF_0005;
    wait_idle("t2", 50, 1'b0);
    check("t2_word_count", word_count, 4);
    // abort while ARMED
    in_valid = 1'b0;
    do_start(2'd1, 32'd0, 1'b0);
    in_valid = 1'b1; sync = 1'b0;
    repeat (3) tick();
    check("t2_armed_idle_low", idle, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    check("t2_abort_idle", idle, 1);
    repeat (2) tick();
    check("t2_abort_no_beats", tvalid, 0);

    // 3: overflow under backpressure, dsize = DEPTH+10
    tready = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) exp_q.push_back({1'b0, pat(i)});
    exp_q.push_back({1'b1, pat(DEPTH + 9)});
    in_valid = 1'b1;
    do_start(2'd0, 32'(DEPTH + 10), 1'b1);
    repeat (DEPTH - 1) tick();
    check("t3_no_ovf_at_depth_m1", overflow, 0);
    check("t3_wc_depth_m1", word_count, DEPTH - 1);
    tick();
    check("t3_ovf_set", overflow, 1);
    repeat (10) tick();
    check("t3_wc_full", word_count, DEPTH + 10);
    check("t3_drain_not_idle", idle, 0);
    check("t3_tvalid", tvalid, 1);
    tready = 1'b1;
    wait_idle("t3", 100, 1'b0);
    check("t3_ovf_sticky", overflow, 1);

    // 4: CONT dsize=2, abort during third packet
    base = last_seen;
    for (int p = 0; p < 3; p++) begin
      exp_q.push_back({1'b0, pat(0)});
      exp_q.push_back({1'b1, pat(1)});
    end
    do_start(2'd2, 32'd2, 1'b1);
    n = 0;
    while (last_seen < base + 2 && n < 100) begin tick(); n++; end
    check("t4_two_packets", last_seen - base, 2);
    abort = 1'b1; tick(); abort = 1'b0;
    wait_idle("t4", 100, 1'b0);
    check("t4_three_packets", last_seen - base, 3);
    repeat (6) tick();
    check("t4_stays_idle", idle, 1);
    check("t4_no_more_beats", tvalid, 0);

    // 5: random stalls, dsize=8
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7) ? 1'b1 : 1'b0, pat(i)});
    tready = 1'b0;
    do_start(2'd0, 32'd8, 1'b1);
    check("t5_ovf_cleared", overflow, 0);
    repeat (3) tick();
    wait_idle("t5", 200, 1'b1);

    // 6: reset during DRAIN
    tready = 1'b0;
    do_start(2'd0, 32'd4, 1'b1);
    repeat (4) tick();
    check("t6_drain_tvalid", tvalid, 1);
    check("t6_drain_idle", idle, 0);
    #2 ARESETN = 1'b0;
    #1;
    check("t6_rst_tvalid", tvalid, 0);
    check("t6_rst_idle", idle, 1);
    check("t6_rst_wc", word_count, 0);
    @(negedge ACLK);
    @(posedge ACLK);
    #1 ARESETN = 1'b1;
    tready = 1'b1;
    exp_q.push_back({1'b1, pat(0)});
    do_start(2'd0, 32'd1, 1'b1);
    wait_idle("t6", 50, 1'b0);
    check("t6_wc", word_count, 1);
    in_valid = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
